// File: rtl/usb_tx_sched.sv
// USB transmit scheduler: arbitrates handshake/token/data requests and serialises
// SYNC, info bits, EOP and inter-packet gap toward the NRZI encoder.
module usb_tx_sched #(
    parameter int EOP_CYC = 2,
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_req,
    input  logic [7:0]  hs_bits,
    input  logic        tok_req,
    input  logic [23:0] tok_bits,
    input  logic        data_req,
    input  logic [87:0] data_bits,
    output logic        bstr_out,
    output logic [1:0]  bstr_out_ready,
    output logic        eop,
    output logic        busy,
    output logic        hs_ack,
    output logic        tok_ack,
    output logic        data_ack
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_INFO = 3'd2,
        S_EOP  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [1:0] TYP_NONE = 2'b00;
    localparam logic [1:0] TYP_TOK  = 2'b01;
    localparam logic [1:0] TYP_DATA = 2'b10;
    localparam logic [1:0] TYP_HS   = 2'b11;

    localparam logic [6:0] SYNC_LAST = 7'd7;
    localparam logic [6:0] EOP_LAST  = 7'(EOP_CYC - 1);
    localparam logic [6:0] GAP_LAST  = 7'(GAP_CYC - 1);

    state_t      state, state_n;
    logic [6:0]  cnt, cnt_n;
    logic [87:0] vec, vec_n;
    logic [1:0]  typ, typ_n;
    logic [6:0]  info_last;

    logic        bstr_n;
    logic [1:0]  ready_n;
    logic        eop_n, busy_n, hs_ack_n, tok_ack_n, data_ack_n;

    always_comb begin
        case (typ)
            TYP_HS:   info_last = 7'd7;
            TYP_TOK:  info_last = 7'd23;
            default:  info_last = 7'd87;
        endcase
    end

    // Next-state logic; outputs are derived from the next state so that the
    // registered outputs line up with the registered state in the same cycle.
    always_comb begin
        state_n = state;
        cnt_n   = 7'(cnt + 7'd1);
        vec_n   = vec;
        typ_n   = typ;
        case (state)
            S_IDLE: begin
                cnt_n = 7'd0;
                if (hs_req) begin
                    state_n = S_SYNC;
                    typ_n   = TYP_HS;
                    vec_n   = {80'd0, hs_bits};
                end else if (tok_req) begin
                    state_n = S_SYNC;
                    typ_n   = TYP_TOK;
                    vec_n   = {64'd0, tok_bits};
                end else if (data_req) begin
                    state_n = S_SYNC;
                    typ_n   = TYP_DATA;
                    vec_n   = data_bits;
                end
            end
            S_SYNC: begin
                if (cnt == SYNC_LAST) begin
                    state_n = S_INFO;
                    cnt_n   = 7'd0;
                end
            end
            S_INFO: begin
                if (cnt == info_last) begin
                    state_n = S_EOP;
                    cnt_n   = 7'd0;
                end
            end
            S_EOP: begin
                if (cnt == EOP_LAST) begin
                    state_n = S_GAP;
                    cnt_n   = 7'd0;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = 7'd0;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 7'd0;
            end
        endcase
    end

    always_comb begin
        bstr_n     = 1'b0;
        ready_n    = TYP_NONE;
        eop_n      = 1'b0;
        busy_n     = (state_n != S_IDLE);
        hs_ack_n   = 1'b0;
        tok_ack_n  = 1'b0;
        data_ack_n = 1'b0;
        case (state_n)
            S_SYNC: begin
                bstr_n  = (cnt_n == SYNC_LAST);
                ready_n = typ_n;
            end
            S_INFO: begin
                bstr_n  = vec_n[cnt_n];
                ready_n = typ_n;
            end
            S_EOP: eop_n = 1'b1;
            S_GAP: begin
                // Ack only on the EOP->GAP transition, i.e. the first gap cycle.
                if (state == S_EOP) begin
                    hs_ack_n   = (typ_n == TYP_HS);
                    tok_ack_n  = (typ_n == TYP_TOK);
                    data_ack_n = (typ_n == TYP_DATA);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= 7'd0;
            vec            <= 88'd0;
            typ            <= TYP_NONE;
            bstr_out       <= 1'b0;
            bstr_out_ready <= TYP_NONE;
            eop            <= 1'b0;
            busy           <= 1'b0;
            hs_ack         <= 1'b0;
            tok_ack        <= 1'b0;
            data_ack       <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            vec            <= vec_n;
            typ            <= typ_n;
            bstr_out       <= bstr_n;
            bstr_out_ready <= ready_n;
            eop            <= eop_n;
            busy           <= busy_n;
            hs_ack         <= hs_ack_n;
            tok_ack        <= tok_ack_n;
            data_ack       <= data_ack_n;
        end
    end

endmodule

// File: doc/usb_tx_sched.md
USB_TX_SCHED -- requirements
Module: usb_tx_sched

Interface
REQ-001 Parameter: EOP_CYC, 2, number of end-of-packet cycles after the last info bit (legal 1..3).
REQ-002 Parameter: GAP_CYC, 2, number of idle cycles after EOP before the next grant (legal 1..7).
REQ-003 Port: clk  input  1  sole clock; all logic on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: hs_req  input  1  handshake send request, level.
REQ-006 Port: hs_bits  input  8  handshake info bits (PID), bit 0 sent first.
REQ-007 Port: tok_req  input  1  token send request, level.
REQ-008 Port: tok_bits  input  24  token info bits (PID, ADDR, ENDP, CRC5), bit 0 sent first.
REQ-009 Port: data_req  input  1  data send request, level.
REQ-010 Port: data_bits  input  88  data info bits (PID, 64 payload, CRC16), bit 0 sent first.
REQ-011 Port: bstr_out  output  1  serial bit to the NRZI encoder.
REQ-012 Port: bstr_out_ready  output  2  packet-type code to the encoder: 00 none, 01 token, 10 data, 11 handshake.
REQ-013 Port: eop  output  1  end-of-packet indication to the line driver.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: hs_ack, tok_ack, data_ack  output  1 each  single-cycle completion pulse per requester.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM SHALL have states IDLE, SYNC, INFO, EOP, GAP.
REQ-018 IDLE: sampling any request SHALL grant exactly one requester and move to SYNC next cycle. Fixed priority: hs > tok > data.
REQ-019 On grant, the chosen bit vector and type code SHALL be latched. Request or bit changes after grant SHALL NOT affect the packet.
REQ-020 SYNC SHALL last 8 cycles and drive bstr_out = 0,0,0,0,0,0,0,1 in order.
REQ-021 INFO SHALL last N cycles (N = 8 hs, 24 tok, 88 data) and drive latched bits LSB first.
REQ-022 bstr_out_ready SHALL hold the latched type code for every SYNC and INFO cycle (8+N cycles) and be 00 otherwise.
REQ-023 EOP SHALL last EOP_CYC cycles with eop=1, bstr_out=0, bstr_out_ready=00.
REQ-024 GAP SHALL last GAP_CYC cycles with all serial outputs 0. The granted requester's ack SHALL pulse high in the first GAP cycle only.
REQ-025 Requests SHALL be ignored for arbitration outside IDLE. Requesters deassert req on the cycle after ack. A req still high in IDLE starts a new packet.
REQ-026 A single 7-bit bit counter SHALL sequence SYNC and INFO, reload at each state entry, and never wrap within a state.
REQ-027 Dropping req mid-packet SHALL NOT abort the packet; ack is still issued.
REQ-028 Grant-to-grant minimum period SHALL be 1 + 8 + N + EOP_CYC + GAP_CYC cycles.

Reset
REQ-029 rst high SHALL, on the next edge, force IDLE, clear the counter, latched vector and type, and drive bstr_out=0, bstr_out_ready=00, eop=0, busy=0, all acks 0.
REQ-030 rst asserted mid-packet SHALL abort the packet without ack. After release, arbitration SHALL restart from IDLE.

Verification
REQ-031 hs_req=1 with hs_bits=8'hD2 from IDLE (defaults) -> SYNC 00000001, then bits 0,1,0,0,1,0,1,1 with bstr_out_ready=11 for 16 cycles, eop=1 for 2 cycles, hs_ack in the next cycle.
REQ-032 hs_req, tok_req and data_req all high in one cycle -> handshake sent first, then token (ready=01 for 32 cycles), then data (ready=10 for 96 cycles). Each ack pulses once, in that order.
REQ-033 tok_req pulsed for 1 cycle and tok_bits changed after grant -> the full 32-cycle token is sent with the latched bits, and tok_ack pulses.
REQ-034 rst asserted at INFO bit 40 of a data packet -> outputs 0 and busy=0 next cycle, no data_ack. With data_req still high after release, the data packet is resent from SYNC.
REQ-035 data_req held continuously -> back-to-back data packets with exactly 1+96+2+2 = 101 cycles between SYNC starts.
